counter_checker: RTL and testbench

- Response checker for the 4-bit multi-mode counter. It is the receiving end of the counter test stimulus.
- Snoops the same enable/reset/mode/D stimulus driven into the counter and carries a cycle-accurate reference model of the counter.
- Each clock, compares the counter outputs against the model and keeps pass/fail statistics.
- Sits beside the DUT in the test harness; synthesizable, so it can also run as an on-chip self-check.

---
 rtl/counter_checker.sv | 233 +++++++++++++++++++++++
 tb/tb_counter_checker.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// ---------------------------------------------------------------------------
// counter_checker
//
// Response checker for the 4-bit multi-mode counter. It watches the same
// stimulus that drives the counter (dut_reset, enable, mode, D), runs its own
// cycle-accurate model of the counter, and compares the counter's outputs
// (q, rco, load) against that model on every clock. It keeps saturating
// error and check statistics and a sticky fail flag. The block is fully
// synthesizable, so it can run as an on-chip self-check as well as in a
// simulation harness.
//
// Parameters
//   CNT_W          width of the saturating err_count / check_count
//   STOP_ON_ERROR  1: freeze in the fail state on the first mismatch
//                  0: keep checking after mismatches
//   MAX_CHECKS     number of compared cycles before entering the done
//                  state; 0 means unlimited
//   FILE           log target name, only used when logging is compiled in
//
// Optional logging
//   Define COUNTER_CHECKER_LOG_EN to announce FILE at time 0, report one line
//   per mismatch and one summary line when the checker enters DONE or FAIL.
//   Without the macro there is no logging; ports and behaviour are the same.
//
// Ports
//   clk          in   single clock, all logic on posedge
//   reset        in   checker reset, synchronous, active-high
//   dut_reset    in   counter reset as driven to the counter
//   enable       in   counter enable as driven to the counter
//   mode [1:0]   in   counter mode (00 +3, 01 -1, 10 +1, 11 load D)
//   D [3:0]      in   counter load data
//   q [3:0]      in   counter count output
//   rco          in   counter ripple-carry output
//   load         in   counter load flag
//   exp_q [3:0]  out  model count
//   mismatch     out  one-cycle pulse per failed compare
//   fail         out  sticky, set on the first mismatch
//   done         out  high in DONE or FAIL
//   err_count    out  saturating count of mismatches
//   check_count  out  saturating count of compared cycles
// ---------------------------------------------------------------------------
module counter_checker #(
   parameter int CNT_W         = 16,
   parameter bit STOP_ON_ERROR = 1'b0,
   parameter int MAX_CHECKS    = 0,
   parameter     FILE          = "./logs/check_A.txt"
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             dut_reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [3:0]       D,
   input  logic [3:0]       q,
   input  logic             rco,
   input  logic             load,
   output logic [3:0]       exp_q,
   output logic             mismatch,
   output logic             fail,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] check_count
);

   // Checker states. IDLE waits for the counter to be reset so the model has
   // a known starting point; CHECK compares every cycle; FAIL and DONE are
   // frozen end states that only the checker reset leaves.
   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_FAIL,
      S_DONE
   } state_t;

   state_t state;

   // Model of the counter's rco and load outputs, registered alongside exp_q.
   logic exp_rco;
   logic exp_load;

   // Next model values computed from the current stimulus.
   logic [3:0] next_q;
   logic       next_rco;
   logic       next_load;

   // Result of comparing the counter outputs with the registered model.
   logic cmp_bad;

   // Saturating increments of the two statistics counters.
   logic [CNT_W-1:0] check_inc;
   logic [CNT_W-1:0] err_inc;

   // Internal compare counter used for the MAX_CHECKS limit. It is kept
   // separate from check_count so a narrow CNT_W (which saturates early)
   // does not prevent the limit from ever being reached.
   logic [31:0] run_count;
   logic [31:0] run_next;
   logic        hit_max;

   // Counter model next-state function. dut_reset has priority over enable,
   // and a disabled counter holds its value while clearing rco and load.
   // rco marks a wrap of the 4-bit count in the counting direction; load
   // is only raised by a load operation.
   always_comb begin
      next_q    = exp_q;
      next_rco  = 1'b0;
      next_load = 1'b0;
      if (dut_reset) begin
         next_q = 4'd0;
      end else if (enable) begin
         case (mode)
            2'b00: begin
               next_q   = exp_q + 4'd3;
               next_rco = (exp_q >= 4'd13);
            end
            2'b01: begin
               next_q   = exp_q - 4'd1;
               next_rco = (exp_q == 4'd0);
            end
            2'b10: begin
               next_q   = exp_q + 4'd1;
               next_rco = (exp_q == 4'd15);
            end
            default: begin
               next_q    = D;
               next_load = 1'b1;
            end
         endcase
      end
   end

   // The compare uses case inequality so an X or Z on any counter output is
   // reported as a mismatch instead of being silently accepted.
   assign cmp_bad = ({q, rco, load} !== {exp_q, exp_rco, exp_load});

   // Saturating increments: the statistics stick at all-ones rather than
   // wrapping back to a small, misleading number.
   assign check_inc = (check_count == {CNT_W{1'b1}}) ? check_count : check_count + CNT_W'(1);
   assign err_inc   = (err_count == {CNT_W{1'b1}}) ? err_count : err_count + CNT_W'(1);
   assign run_next  = (run_count == 32'hFFFF_FFFF) ? run_count : run_count + 32'd1;
   assign hit_max   = (MAX_CHECKS > 0) && (run_next == 32'(MAX_CHECKS));

   // Main checker state machine. Everything, including the model, is reset
   // synchronously by the checker reset, which also beats a simultaneous
   // dut_reset. In IDLE the model is only meaningful once the counter has
   // been reset, so the first dut_reset arms the checker with a cleared
   // model. In CHECK each edge compares the outputs against the model
   // registered on the previous edge, then advances the model; mismatch,
   // fail and err_count all reflect that compare from the same edge.
   // FAIL and DONE freeze the model and statistics until the checker reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         exp_q       <= 4'd0;
         exp_rco     <= 1'b0;
         exp_load    <= 1'b0;
         mismatch    <= 1'b0;
         fail        <= 1'b0;
         done        <= 1'b0;
         err_count   <= '0;
         check_count <= '0;
         run_count   <= '0;
      end else begin
         mismatch <= 1'b0;
         case (state)
            S_IDLE: begin
               if (dut_reset) begin
                  state    <= S_CHECK;
                  exp_q    <= 4'd0;
                  exp_rco  <= 1'b0;
                  exp_load <= 1'b0;
               end
            end
            S_CHECK: begin
               exp_q       <= next_q;
               exp_rco     <= next_rco;
               exp_load    <= next_load;
               check_count <= check_inc;
               run_count   <= run_next;
               if (cmp_bad) begin
                  mismatch  <= 1'b1;
                  fail      <= 1'b1;
                  err_count <= err_inc;
               end
               if (cmp_bad && STOP_ON_ERROR) begin
                  state <= S_FAIL;
                  done  <= 1'b1;
               end else if (hit_max) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            default: begin
               done <= 1'b1;
            end
         endcase
      end
   end

`ifdef COUNTER_CHECKER_LOG_EN
   // Simulation-only logging. One line per failed compare with the stimulus,
   // the expected and the actual outputs, and one summary line the first
   // time the checker reaches an end state after a reset.
   logic done_seen;

   initial begin
      done_seen = 1'b0;
      $display("%0t log %s", $time, FILE);
   end

   always @(posedge clk) begin
      if (reset) begin
         done_seen <= 1'b0;
      end else begin
         if ((state == S_CHECK) && cmp_bad) begin
            $display("%0t check=%0d mode=%b enable=%b dut_reset=%b D=%h exp q=%h rco=%b load=%b act q=%h rco=%b load=%b",
                     $time, check_inc, mode, enable, dut_reset, D,
                     exp_q, exp_rco, exp_load, q, rco, load);
         end
         if (done && !done_seen) begin
            $display("%0t summary err_count=%0d check_count=%0d",
                     $time, err_count, check_count);
            done_seen <= 1'b1;
         end
      end
   end
`else
   // FILE only feeds the logging build; this empty block just consumes it.
   if ($bits(FILE) == 0) begin : g_no_log_file
   end
`endif

endmodule

// File: tb/tb_counter_checker.sv
// ---------------------------------------------------------------------------
// tb_counter_checker
//
// Drives the checker with counter stimulus and plays the part of the counter
// itself, producing correct q/rco/load with optional injected faults. Three
// checker configurations see the same stimulus: default, stop-on-error, and
// narrow counters with a MAX_CHECKS limit. Expected checker responses come
// from a behavioural model and go into a scoreboard queue; a separate
// monitor pops and compares them after each clock edge.
// ---------------------------------------------------------------------------
module tb_counter_checker;

   localparam int NCFG = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic dut_reset = 1'b0;
   logic enable = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] D = 4'd0;
   logic [3:0] q = 4'd0;
   logic rco = 1'b0;
   logic load = 1'b0;

   logic [3:0] expQ0, expQ1, expQ2;
   logic [2:0] mismV, failV, doneV;
   logic [15:0] errA, chkA, errB, chkB;
   logic [1:0] errC, chkC;

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   counter_checker u0 (
      .clk(clk), .reset(reset), .dut_reset(dut_reset), .enable(enable),
      .mode(mode), .D(D), .q(q), .rco(rco), .load(load),
      .exp_q(expQ0), .mismatch(mismV[0]), .fail(failV[0]), .done(doneV[0]),
      .err_count(errA), .check_count(chkA)
   );

   counter_checker #(.STOP_ON_ERROR(1'b1)) u1 (
      .clk(clk), .reset(reset), .dut_reset(dut_reset), .enable(enable),
      .mode(mode), .D(D), .q(q), .rco(rco), .load(load),
      .exp_q(expQ1), .mismatch(mismV[1]), .fail(failV[1]), .done(doneV[1]),
      .err_count(errB), .check_count(chkB)
   );

   counter_checker #(.CNT_W(2), .MAX_CHECKS(8)) u2 (
      .clk(clk), .reset(reset), .dut_reset(dut_reset), .enable(enable),
      .mode(mode), .D(D), .q(q), .rco(rco), .load(load),
      .exp_q(expQ2), .mismatch(mismV[2]), .fail(failV[2]), .done(doneV[2]),
      .err_count(errC), .check_count(chkC)
   );

   // Behavioural view of one checker: whether it has been armed by a counter
   // reset, whether it is frozen, its counter model and its statistics.
   typedef struct {
      bit armed;
      bit frozen;
      int cnt;
      bit rco;
      bit load;
      int errs;
      int chks;
      int runs;
      bit fl;
      bit dn;
      bit mism;
   } refState_t;

   typedef struct {
      int cfg;
      int q;
      bit mism;
      bit fl;
      bit dn;
      int errs;
      int chks;
   } expect_t;

   refState_t refm [NCFG];
   expect_t   sbq [$];

   int satMax  [NCFG] = '{65535, 65535, 3};
   bit stopCfg [NCFG] = '{1'b0, 1'b1, 1'b0};
   int maxCfg  [NCFG] = '{0, 0, 8};

   // State of a correctly behaving counter, driven onto q/rco/load.
   int trueCnt  = 0;
   bit trueRco  = 1'b0;
   bit trueLoad = 1'b0;

   int vectors = 0;
   int miscompares = 0;

   // Counter behaviour from the mode table: compute the raw arithmetic
   // result and flag a carry whenever it leaves the 0..15 range.
   function automatic void counterStep(input int c, input bit drst, input bit en,
                                       input bit [1:0] md, input int d,
                                       output int nc, output bit nrco, output bit nload);
      int raw;
      nc    = c;
      nrco  = 1'b0;
      nload = 1'b0;
      if (drst) begin
         nc = 0;
      end else if (en) begin
         if (md == 2'b11) begin
            nc    = d;
            nload = 1'b1;
         end else begin
            raw  = (md == 2'b00) ? c + 3 : (md == 2'b01) ? c - 1 : c + 1;
            nrco = (raw > 15) || (raw < 0);
            nc   = (raw + 16) % 16;
         end
      end
   endfunction

   // One clock edge of checker behaviour for configuration i.
   task automatic refStep(input int i, input bit rst, input bit drst, input bit en,
                          input bit [1:0] md, input int d, input int qv,
                          input bit rv, input bit lv);
      bit bad;
      if (rst) begin
         refm[i] = '{default: 0};
      end else if (!refm[i].armed) begin
         refm[i].mism = 1'b0;
         if (drst) begin
            refm[i].armed = 1'b1;
            refm[i].cnt   = 0;
            refm[i].rco   = 1'b0;
            refm[i].load  = 1'b0;
         end
      end else if (refm[i].frozen) begin
         refm[i].mism = 1'b0;
      end else begin
         bad = (qv != refm[i].cnt) || (rv != refm[i].rco) || (lv != refm[i].load);
         refm[i].runs = refm[i].runs + 1;
         refm[i].chks = (refm[i].chks + 1 > satMax[i]) ? satMax[i] : refm[i].chks + 1;
         refm[i].mism = bad;
         if (bad) begin
            refm[i].fl   = 1'b1;
            refm[i].errs = (refm[i].errs + 1 > satMax[i]) ? satMax[i] : refm[i].errs + 1;
         end
         counterStep(refm[i].cnt, drst, en, md, d, refm[i].cnt, refm[i].rco, refm[i].load);
         if ((bad && stopCfg[i]) || (maxCfg[i] > 0 && refm[i].runs == maxCfg[i])) begin
            refm[i].frozen = 1'b1;
            refm[i].dn     = 1'b1;
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      vectors++;
      if (act !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   // Applies one cycle of stimulus at a negedge, records the expected
   // checker response after the coming posedge, then advances the counter.
   // flip[3:0] corrupts q and flip[4] corrupts rco for this cycle.
   task automatic applyStimulus(input bit rst, input bit drst, input bit en,
                                input bit [1:0] md, input int d, input bit [4:0] flip);
      int qv;
      bit rv;
      expect_t e;
      qv        = trueCnt ^ int'(flip[3:0]);
      rv        = trueRco ^ flip[4];
      reset     = rst;
      dut_reset = drst;
      enable    = en;
      mode      = md;
      D         = 4'(d);
      q         = 4'(qv);
      rco       = rv;
      load      = trueLoad;
      for (int i = 0; i < NCFG; i++) begin
         refStep(i, rst, drst, en, md, d, qv, rv, trueLoad);
         e.cfg  = i;
         e.q    = refm[i].cnt;
         e.mism = refm[i].mism;
         e.fl   = refm[i].fl;
         e.dn   = refm[i].dn;
         e.errs = refm[i].errs;
         e.chks = refm[i].chks;
         sbq.push_back(e);
      end
      counterStep(trueCnt, drst, en, md, d, trueCnt, trueRco, trueLoad);
      @(negedge clk);
   endtask

   task automatic getOutputs(input int i, output logic [31:0] aq, output logic [31:0] am,
                             output logic [31:0] af, output logic [31:0] ad,
                             output logic [31:0] ae, output logic [31:0] ac);
      am = {31'd0, mismV[i]};
      af = {31'd0, failV[i]};
      ad = {31'd0, doneV[i]};
      case (i)
         0: begin aq = {28'd0, expQ0}; ae = {16'd0, errA}; ac = {16'd0, chkA}; end
         1: begin aq = {28'd0, expQ1}; ae = {16'd0, errB}; ac = {16'd0, chkB}; end
         default: begin aq = {28'd0, expQ2}; ae = {30'd0, errC}; ac = {30'd0, chkC}; end
      endcase
   endtask

   // Scoreboard monitor: shortly after every posedge, pop the responses
   // predicted for that edge and compare them with the checker outputs.
   initial begin
      expect_t e;
      logic [31:0] aq, am, af, ad, ae, ac;
      forever begin
         @(posedge clk);
         #1;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            getOutputs(e.cfg, aq, am, af, ad, ae, ac);
            checkOutput($sformatf("cfg%0d.exp_q", e.cfg), aq, e.q);
            checkOutput($sformatf("cfg%0d.mismatch", e.cfg), am, {31'd0, e.mism});
            checkOutput($sformatf("cfg%0d.fail", e.cfg), af, {31'd0, e.fl});
            checkOutput($sformatf("cfg%0d.done", e.cfg), ad, {31'd0, e.dn});
            checkOutput($sformatf("cfg%0d.err_count", e.cfg), ae, e.errs);
            checkOutput($sformatf("cfg%0d.check_count", e.cfg), ac, e.chks);
         end
      end
   end

   // Watchdog so the run always ends on its own.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] time limit reached");
   end

   // Directed phases followed by a randomized phase.
   initial begin
      @(negedge clk);

      // Checker reset, counter reset, then 20 correct up-counts.
      applyStimulus(1, 0, 0, 2'b00, 0, 5'd0);
      applyStimulus(0, 1, 1, 2'b10, 0, 5'd0);
      repeat (20) applyStimulus(0, 0, 1, 2'b10, 0, 5'd0);
      checkOutput("up20.check_count", {16'd0, chkA}, 20);
      checkOutput("up20.err_count", {16'd0, errA}, 0);
      checkOutput("up20.fail", {31'd0, failV[0]}, 0);
      checkOutput("up20.exp_q", {28'd0, expQ0}, 4);
      checkOutput("up20.max_done", {31'd0, doneV[2]}, 1);
      checkOutput("up20.narrow_check_count", {30'd0, chkC}, 3);

      // Checker reset together with counter reset: checker reset wins.
      applyStimulus(1, 1, 1, 2'b10, 0, 5'd0);
      checkOutput("bothrst.check_count", {16'd0, chkA}, 0);
      checkOutput("bothrst.done", {31'd0, doneV[2]}, 0);
      applyStimulus(0, 1, 1, 2'b10, 0, 5'd0);
      repeat (5) applyStimulus(0, 0, 1, 2'b10, 0, 5'd0);
      // Counter shows 6 where 5 is expected.
      applyStimulus(0, 0, 1, 2'b10, 0, 5'b00011);
      checkOutput("inject.mismatch", {31'd0, mismV[0]}, 1);
      checkOutput("inject.err_count", {16'd0, errA}, 1);
      checkOutput("inject.fail", {31'd0, failV[0]}, 1);
      checkOutput("inject.stop_done", {31'd0, doneV[1]}, 1);
      applyStimulus(0, 0, 1, 2'b10, 0, 5'd0);
      checkOutput("inject.pulse_end", {31'd0, mismV[0]}, 0);
      checkOutput("inject.fail_sticky", {31'd0, failV[0]}, 1);
      applyStimulus(0, 0, 1, 2'b10, 0, 5'b10000);
      checkOutput("second.err_count", {16'd0, errA}, 2);
      checkOutput("second.stop_err_count", {16'd0, errB}, 1);
      checkOutput("second.stop_check_count", {16'd0, chkB}, 6);
      checkOutput("second.stop_done", {31'd0, doneV[1]}, 1);

      // Wrap cases in both directions, and load against counter reset.
      applyStimulus(1, 0, 0, 2'b00, 0, 5'd0);
      applyStimulus(0, 1, 0, 2'b00, 0, 5'd0);
      applyStimulus(0, 0, 1, 2'b11, 14, 5'd0);
      checkOutput("wrap.load14", {28'd0, expQ0}, 14);
      applyStimulus(0, 0, 1, 2'b00, 0, 5'd0);
      checkOutput("wrap.plus3", {28'd0, expQ0}, 1);
      applyStimulus(0, 0, 1, 2'b01, 0, 5'd0);
      applyStimulus(0, 0, 1, 2'b01, 0, 5'd0);
      checkOutput("wrap.minus1", {28'd0, expQ0}, 15);
      applyStimulus(0, 1, 1, 2'b11, 9, 5'd0);
      checkOutput("ldrst.exp_q", {28'd0, expQ0}, 0);
      applyStimulus(0, 0, 1, 2'b11, 9, 5'd0);
      checkOutput("ldrst.load9", {28'd0, expQ0}, 9);
      applyStimulus(0, 0, 0, 2'b00, 0, 5'd0);
      checkOutput("wrap.err_count", {16'd0, errA}, 0);
      checkOutput("wrap.check_count", {16'd0, chkA}, 7);

      // Five consecutive errors: narrow counters saturate, then hit the limit.
      applyStimulus(1, 0, 0, 2'b00, 0, 5'd0);
      applyStimulus(0, 1, 1, 2'b10, 0, 5'd0);
      repeat (5) applyStimulus(0, 0, 1, 2'b10, 0, 5'b00001);
      checkOutput("burst.narrow_err_count", {30'd0, errC}, 3);
      checkOutput("burst.mismatch", {31'd0, mismV[2]}, 1);
      checkOutput("burst.err_count", {16'd0, errA}, 5);
      repeat (3) applyStimulus(0, 0, 1, 2'b10, 0, 5'd0);
      checkOutput("burst.max_done", {31'd0, doneV[2]}, 1);
      checkOutput("burst.narrow_check_count", {30'd0, chkC}, 3);
      checkOutput("burst.pulse_end", {31'd0, mismV[2]}, 0);

      // Randomized stimulus with occasional resets and injected faults.
      repeat (400) begin
         bit r, dr, en;
         bit [1:0] md;
         int d;
         bit [4:0] fl;
         r  = ($urandom_range(99) < 2);
         dr = ($urandom_range(99) < 6);
         en = ($urandom_range(99) < 85);
         md = 2'($urandom_range(3));
         d  = int'($urandom_range(15));
         fl = ($urandom_range(99) < 8) ? 5'($urandom_range(31, 1)) : 5'd0;
         applyStimulus(r, dr, en, md, d, fl);
      end

      applyStimulus(0, 0, 0, 2'b00, 0, 5'd0);
      applyStimulus(0, 0, 0, 2'b00, 0, 5'd0);
      checkOutput("scoreboard.drained", sbq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
